// File: rtl/rv_bp_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv_bp_pkg
// Purpose  : Shared encodings, FSM states and saturating helpers for the
//            bimodal branch predictor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_bp_pkg;

    localparam logic [1:0] BP_SNT      = 2'b00;
    localparam logic [1:0] BP_WNT      = 2'b01;
    localparam logic [1:0] BP_WT       = 2'b10;
    localparam logic [1:0] BP_STT      = 2'b11;
    localparam logic [1:0] BP_INIT_VAL = BP_WNT;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [1:0] bp_sat_inc(input logic [1:0] cnt);
        return (cnt == BP_STT) ? BP_STT : cnt + 2'd1;
    endfunction

    function automatic logic [1:0] bp_sat_dec(input logic [1:0] cnt);
        return (cnt == BP_SNT) ? BP_SNT : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_counter_table.sv
//------------------------------------------------------------------------------
// Module   : bp_counter_table
// Purpose  : ENTRIES x 2-bit saturating counter array, one read-modify-write
//            port and one read port with write-first bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_counter_table
    import rv_bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                in_clk,
    input  logic                in_wr_en,
    input  logic                in_wr_init,
    input  logic [IDX_BITS-1:0] in_wr_idx,
    input  logic                in_wr_taken,
    input  logic [IDX_BITS-1:0] in_rd_idx,
    output logic [1:0]          out_rd_cnt,
    output logic [1:0]          out_wr_old
);

    logic [1:0] mem_q [ENTRIES];
    logic [1:0] wr_new;
    logic [1:0] rd_raw;

    always_comb begin
        out_wr_old = mem_q[in_wr_idx];
        rd_raw     = mem_q[in_rd_idx];
        if (in_wr_init) begin
            wr_new = BP_INIT_VAL;
        end else if (in_wr_taken) begin
            wr_new = bp_sat_inc(out_wr_old);
        end else begin
            wr_new = bp_sat_dec(out_wr_old);
        end
        // Reader sees the value being written this cycle to the same entry.
        out_rd_cnt = (in_wr_en && (in_wr_idx == in_rd_idx)) ? wr_new : rd_raw;
    end

    always_ff @(posedge in_clk) begin
        if (in_wr_en) begin
            mem_q[in_wr_idx] <= wr_new;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
//------------------------------------------------------------------------------
// Module   : branch_predict_unit
// Purpose  : Bimodal predictor: init sweep FSM, registered prediction, and
//            optional statistics counters (macro BP_STATS_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_predict_unit
    import rv_bp_pkg::*;
#(
    parameter int ENTRIES = 256,
    parameter int CNT_W   = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_lookup_valid,
    input  logic [63:0]      in_lookup_pc,
    input  logic             in_stall,
    input  logic             in_flush,
    input  logic             in_update_valid,
    input  logic [63:0]      in_update_pc,
    input  logic             in_update_taken,
    output logic             out_prediction,
    output logic             out_ready,
    output logic [CNT_W-1:0] out_lookup_count,
    output logic [CNT_W-1:0] out_mispredict_cnt
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    bp_state_e           state_q, state_d;
    logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    logic                pred_q, pred_d;

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] update_idx;
    logic                wr_en;
    logic                wr_init;
    logic [IDX_BITS-1:0] wr_idx;
    logic [1:0]          rd_cnt;
    logic [1:0]          wr_old;
    logic                run;

    assign lookup_idx = in_lookup_pc[IDX_BITS+1:2];
    assign update_idx = in_update_pc[IDX_BITS+1:2];
    assign run        = (state_q == BP_RUN);

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        pred_d      = pred_q;
        wr_en       = 1'b0;
        wr_init     = 1'b0;
        wr_idx      = update_idx;
        if (in_rst) begin
            state_d     = BP_INIT;
            sweep_idx_d = '0;
            pred_d      = 1'b0;
        end else if (!run) begin
            wr_en       = 1'b1;
            wr_init     = 1'b1;
            wr_idx      = sweep_idx_q;
            sweep_idx_d = sweep_idx_q + IDX_BITS'(1);
            pred_d      = 1'b0;
            if (sweep_idx_q == IDX_BITS'(ENTRIES - 1)) begin
                state_d = BP_RUN;
            end
        end else begin
            wr_en = in_update_valid;
            if (in_flush) begin
                pred_d = 1'b0;
            end else if (!in_stall) begin
                pred_d = in_lookup_valid & rd_cnt[1];
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= BP_INIT;
            sweep_idx_q <= '0;
            pred_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            pred_q      <= pred_d;
        end
    end

    bp_counter_table #(
        .ENTRIES  (ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_table (
        .in_clk      (in_clk),
        .in_wr_en    (wr_en),
        .in_wr_init  (wr_init),
        .in_wr_idx   (wr_idx),
        .in_wr_taken (in_update_taken),
        .in_rd_idx   (lookup_idx),
        .out_rd_cnt  (rd_cnt),
        .out_wr_old  (wr_old)
    );

    assign out_prediction = pred_q;
    assign out_ready      = run;

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             unused_pc_bits;

    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (run && in_lookup_valid && !in_stall && !in_flush) begin
            lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
        end
        if (run && in_update_valid && (wr_old[1] != in_update_taken)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign out_lookup_count   = lookup_cnt_q;
    assign out_mispredict_cnt = mispred_cnt_q;
    assign unused_pc_bits     = ^{in_lookup_pc[63:IDX_BITS+2], in_lookup_pc[1:0],
                                  in_update_pc[63:IDX_BITS+2], in_update_pc[1:0], wr_old[0]};
`else
    logic unused_pc_bits;

    assign out_lookup_count   = '0;
    assign out_mispredict_cnt = '0;
    assign unused_pc_bits     = ^{in_lookup_pc[63:IDX_BITS+2], in_lookup_pc[1:0],
                                  in_update_pc[63:IDX_BITS+2], in_update_pc[1:0], wr_old};
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_branch_predict_unit
// Purpose  : Directed and randomized bench for branch_predict_unit against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predict_unit;

    localparam int ENTRIES = 256;
    localparam int CNT_W   = 32;

    logic             in_clk = 1'b0;
    logic             in_rst;
    logic             in_lookup_valid;
    logic [63:0]      in_lookup_pc;
    logic             in_stall;
    logic             in_flush;
    logic             in_update_valid;
    logic [63:0]      in_update_pc;
    logic             in_update_taken;
    logic             out_prediction;
    logic             out_ready;
    logic [CNT_W-1:0] out_lookup_count;
    logic [CNT_W-1:0] out_mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    int               m_tab [ENTRIES];
    int               m_init_left = ENTRIES;
    bit               m_pred = 1'b0;
    logic [CNT_W-1:0] m_lk = '0;
    logic [CNT_W-1:0] m_mp = '0;

    always #5 in_clk = ~in_clk;

    branch_predict_unit #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_lookup_valid    (in_lookup_valid),
        .in_lookup_pc       (in_lookup_pc),
        .in_stall           (in_stall),
        .in_flush           (in_flush),
        .in_update_valid    (in_update_valid),
        .in_update_pc       (in_update_pc),
        .in_update_taken    (in_update_taken),
        .out_prediction     (out_prediction),
        .out_ready          (out_ready),
        .out_lookup_count   (out_lookup_count),
        .out_mispredict_cnt (out_mispredict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge, compare.
    task automatic cyc(input logic rst, input logic lv, input logic [63:0] lpc,
                       input logic st, input logic fl,
                       input logic uv, input logic [63:0] upc, input logic ut);
        int ui;
        int li;
        int old;
        in_rst          = rst;
        in_lookup_valid = lv;
        in_lookup_pc    = lpc;
        in_stall        = st;
        in_flush        = fl;
        in_update_valid = uv;
        in_update_pc    = upc;
        in_update_taken = ut;
        @(posedge in_clk);
        ui = int'((upc >> 2) % ENTRIES);
        li = int'((lpc >> 2) % ENTRIES);
        if (rst) begin
            m_init_left = ENTRIES;
            m_pred      = 1'b0;
            m_lk        = '0;
            m_mp        = '0;
        end else if (m_init_left > 0) begin
            m_tab[ENTRIES - m_init_left] = 1;
            m_init_left--;
            m_pred = 1'b0;
        end else begin
            if (uv) begin
                old = m_tab[ui];
                if ((old >= 2) != ut) m_mp++;
                m_tab[ui] = ut ? ((old < 3) ? old + 1 : 3) : ((old > 0) ? old - 1 : 0);
            end
            if (fl) begin
                m_pred = 1'b0;
            end else if (!st) begin
                m_pred = lv && (m_tab[li] >= 2);
                if (lv) m_lk++;
            end
        end
        #1;
        check("ready", 64'(out_ready), 64'(m_init_left == 0));
        check("pred", 64'(out_prediction), 64'(m_pred));
`ifdef BP_STATS_EN
        check("lookup_cnt", 64'(out_lookup_count), 64'(m_lk));
        check("mispred_cnt", 64'(out_mispredict_cnt), 64'(m_mp));
`else
        check("lookup_cnt", 64'(out_lookup_count), 64'd0);
        check("mispred_cnt", 64'(out_mispredict_cnt), 64'd0);
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic lookup(input logic [63:0] pc);
        cyc(1'b0, 1'b1, pc, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic update(input logic [63:0] pc, input logic taken);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, pc, taken);
    endtask

    task automatic reset_and_wait(output int low_cycles);
        cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        check("rst_ready", 64'(out_ready), 64'd0);
        check("rst_pred", 64'(out_prediction), 64'd0);
        check("rst_lk", 64'(out_lookup_count), 64'd0);
        check("rst_mp", 64'(out_mispredict_cnt), 64'd0);
        low_cycles = (out_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 270; i++) begin
            idle();
            if (out_ready == 1'b0) low_cycles++;
        end
    endtask

    initial begin
        int low;
        logic [63:0] lpc;
        logic [63:0] upc;
        for (int i = 0; i < ENTRIES; i++) m_tab[i] = 0;

        // Init sweep length and quiet outputs.
        reset_and_wait(low);
        check("init_cycles", 64'(low), 64'd256);
        check("ready_after_init", 64'(out_ready), 64'd1);

        // Fresh table predicts not-taken.
        lookup(64'h2000);
        check("fresh_lookup", 64'(out_prediction), 64'd0);

        // Training and saturation.
        update(64'h1000, 1'b1);
        update(64'h1000, 1'b1);
        lookup(64'h1000);
        check("trained", 64'(out_prediction), 64'd1);
        update(64'h1000, 1'b1);
        update(64'h1000, 1'b1);
        update(64'h1000, 1'b0);
        lookup(64'h1000);
        check("saturated", 64'(out_prediction), 64'd1);

        // Aliasing: 0x1400 shares an index with 0x1000, 0x1004 does not.
        update(64'h1000, 1'b1);
        update(64'h1000, 1'b1);
        lookup(64'h1400);
        check("alias_hit", 64'(out_prediction), 64'd1);
        lookup(64'h1004);
        check("alias_miss", 64'(out_prediction), 64'd0);

        // Same-cycle update and lookup to a weak-NT entry.
        cyc(1'b0, 1'b1, 64'h2008, 1'b0, 1'b0, 1'b1, 64'h2008, 1'b1);
        check("bypass", 64'(out_prediction), 64'd1);

        // Stall hold, then flush overriding stall and lookup.
        lookup(64'h1000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 64'h1004, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
            check("stall_hold", 64'(out_prediction), 64'd1);
        end
        cyc(1'b0, 1'b1, 64'h1000, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        check("flush", 64'(out_prediction), 64'd0);

        // Mid-run reset re-sweeps the trained entry.
        reset_and_wait(low);
        check("reinit_cycles", 64'(low), 64'd256);
        lookup(64'h1000);
        check("reinit_entry", 64'(out_prediction), 64'd0);

        // Stats: 5 lookups total (one above) and 2 mispredicting updates.
        for (int i = 0; i < 4; i++) lookup(64'h3000 + 64'(i * 4));
        update(64'h3100, 1'b1);
        update(64'h3104, 1'b1);
`ifdef BP_STATS_EN
        check("stats_lk", 64'(out_lookup_count), 64'd5);
        check("stats_mp", 64'(out_mispredict_cnt), 64'd2);
`else
        check("stats_lk", 64'(out_lookup_count), 64'd0);
        check("stats_mp", 64'(out_mispredict_cnt), 64'd0);
`endif

        // Randomized traffic on a small PC pool to force hits and aliases.
        for (int n = 0; n < 3000; n++) begin
            lpc = (64'($urandom_range(0, 15)) << 2) | (64'($urandom_range(0, 3)) << 10);
            upc = (64'($urandom_range(0, 15)) << 2) | (64'($urandom_range(0, 3)) << 10);
            if ($urandom_range(0, 7) == 0) upc = lpc;
            cyc(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)), lpc,
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
